apu_oam_dma: RTL



---
 rtl/apu_oam_dma.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/apu_oam_dma.sv
// Sprite/OAM DMA bus master: a CPU write of a page number to DMA_REG copies COUNT
// bytes from {page, index} to the PPU OAM data port at DEST, one read and one write per byte.
module apu_oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter logic [15:0] DEST    = 16'h2004,
    parameter int unsigned COUNT   = 256
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] bus_addr,
    input  logic        bus_we,
    input  logic [7:0]  bus_data,
    input  logic        get_cycle,
    input  logic        gnt,
    output logic        req,
    output logic        m_oe,
    output logic [15:0] m_addr,
    output logic [7:0]  m_data,
    output logic        m_we,
    output logic        busy
);

    localparam logic [7:0] LAST_INDEX = 8'(COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  buf_q, buf_d;
    logic        req_q, req_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        trigger;

    assign trigger = bus_we && (bus_addr == DMA_REG) && !m_oe;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        buf_d   = buf_q;

        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_REQ;
                    page_d  = bus_data;
                    index_d = '0;
                end
            end
            S_REQ: begin
                if (gnt) state_d = get_cycle ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                if (gnt && get_cycle) state_d = S_READ;
            end
            S_READ: begin
                // A read that loses the grant never latches; it is simply repeated.
                if (gnt) begin
                    buf_d   = bus_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (gnt) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                index_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        req_d  = state_d inside {S_REQ, S_ALIGN, S_READ, S_WRITE};
        oe_d   = state_d inside {S_ALIGN, S_READ, S_WRITE};
        we_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        addr_d = '0;
        data_d = '0;
        case (state_d)
            S_ALIGN, S_WRITE: addr_d = DEST;
            S_READ:           addr_d = {page_d, index_d};
            default:          addr_d = '0;
        endcase
        if (state_d == S_WRITE) data_d = buf_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            page_q  <= '0;
            index_q <= '0;
            buf_q   <= '0;
            req_q   <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Bus drivers release in the same cycle the arbiter withdraws the grant.
    assign req    = req_q;
    assign busy   = busy_q;
    assign m_oe   = oe_q & gnt;
    assign m_we   = we_q & gnt;
    assign m_addr = addr_q;
    assign m_data = m_we ? data_q : 8'h00;

endmodule
